// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

  // Bit counter width: max(1, clog2(width)) so a 1-bit datapath still has a counter bit.
  function automatic int sa_cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic cell in the serial engine.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  assign half = a ^ b;
  assign sum  = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full adder stepped LSB-first over DATA_WIDTH cycles,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int DATA_WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int            CW   = sa_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  sa_state_t             state;
  logic [CW-1:0]         cnt;
  logic                  carry;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] result_shifted;
  logic                  fa_sum;
  logic                  fa_cout;

  // Operands shift right each RUN cycle, so bit cnt is always presented at position 0.
  full_adder u_full_adder (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  generate
    if (DATA_WIDTH == 1) begin : g_single_bit
      assign result_shifted = fa_sum;
    end else begin : g_multi_bit
      assign result_shifted = {fa_sum, result[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          carry  <= fa_cout;
          result <= result_shifted;
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          if (cnt == LAST) begin
            overflow  <= carry ^ fa_cout;
            carry_out <= fa_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (8-bit and 1-bit instances) with a result scoreboard.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       resetn;
  logic       in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow, busy;
  logic [7:0] a, b, result;

  logic       in_valid1, in_ready1, a1, b1, sub1, out_valid1, out_ready1;
  logic       result1, carry_out1, overflow1, busy1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out  = 0;
  logic [33:0] sb[$];
  int          acc_cyc[$];

  serial_adder_ctrl #(.DATA_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  serial_adder_ctrl #(.DATA_WIDTH(1)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .carry_out(carry_out1), .overflow(overflow1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry_out, overflow, result} of x +/- y at width w.
  function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y, input logic s);
    logic [32:0] mask, xe, ye, tot;
    logic [31:0] r;
    logic        co, ov;
    mask = (33'd1 << w) - 33'd1;
    xe   = {1'b0, x} & mask;
    ye   = (s ? ~{1'b0, y} : {1'b0, y}) & mask;
    tot  = xe + ye + {32'd0, s};
    r    = tot[31:0] & mask[31:0];
    co   = tot[w];
    ov   = (xe[w-1] == ye[w-1]) && (r[w-1] != xe[w-1]);
    return {co, ov, r};
  endfunction

  // Scoreboard: push on accept, pop and compare on result handshake (sampled mid-cycle).
  always @(negedge clk) begin
    logic [33:0] exp;
    if (resetn && in_valid && in_ready) begin
      sb.push_back(model(8, {24'd0, a}, {24'd0, b}, sub));
      acc_cyc.push_back(cyc);
    end
    if (resetn && out_valid && out_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("sb_result", {24'd0, result}, exp[31:0]);
        check("sb_carry_out", {31'd0, carry_out}, {31'd0, exp[33]});
        check("sb_overflow", {31'd0, overflow}, {31'd0, exp[32]});
        n_out++;
      end
    end
  end

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic s);
    int n = 0;
    a = x; b = y; sub = s; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_out(input int exp_lat);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, exp_lat);
    check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic finish_out();
    @(posedge clk); #1;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic flags(input string tag, input logic [7:0] r, input logic co, input logic ov);
    check({tag, "_result"}, {24'd0, result}, {24'd0, r});
    check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, co});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ov});
  endtask

  initial begin
    logic [33:0] e1;
    int n;
    resetn = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    flags("rst", 8'h00, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    start_op(8'h0F, 8'h01, 1'b0); wait_out(8); flags("add_0f_01", 8'h10, 1'b0, 1'b0); finish_out();
    start_op(8'h7F, 8'h01, 1'b0); wait_out(8); flags("add_7f_01", 8'h80, 1'b0, 1'b1); finish_out();
    start_op(8'hFF, 8'h01, 1'b0); wait_out(8); flags("add_ff_01", 8'h00, 1'b1, 1'b0); finish_out();
    start_op(8'h05, 8'h07, 1'b1); wait_out(8); flags("sub_05_07", 8'hFE, 1'b0, 1'b0); finish_out();
    start_op(8'h80, 8'h01, 1'b1); wait_out(8); flags("sub_80_01", 8'h7F, 1'b1, 1'b1); finish_out();

    // Backpressure: DONE held with outputs frozen.
    out_ready = 1'b0;
    start_op(8'h3C, 8'h0C, 1'b1); wait_out(8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      flags("bp", 8'h30, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    finish_out();

    // New operands offered mid-RUN must be ignored.
    start_op(8'h11, 8'h22, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
    check("iso_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(4); flags("iso", 8'h33, 1'b0, 1'b0); finish_out();

    // Reset during RUN cycle 3 discards the operation.
    start_op(8'h55, 8'h0A, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    flags("mid_rst", 8'h00, 1'b0, 1'b0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("no_out_after_rst", n, 0);
    start_op(8'h12, 8'h34, 1'b0); wait_out(8); flags("post_rst", 8'h46, 1'b0, 1'b0); finish_out();

    // Back-to-back with both handshakes held high.
    acc_cyc.delete();
    a = 8'h21; b = 8'h13; sub = 1'b0; in_valid = 1'b1;
    repeat (35) begin @(posedge clk); #1; end
    n = 0;
    while (in_ready && n < 20) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    n = 0;
    while (!(in_ready && !out_valid) && n < 30) begin @(posedge clk); #1; n++; end
    check("b2b_drained", {31'd0, in_ready}, 32'd1);
    check("b2b_accepts", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 10);
    check("sb_empty", sb.size(), 0);
    check("outputs_seen", n_out, 12);

    // 1-bit instance: single RUN cycle.
    a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0; in_valid1 = 1'b1;
    check("w1_in_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    e1 = model(1, 32'd1, 32'd1, 1'b0);
    check("w1_out_valid", {31'd0, out_valid1}, 32'd1);
    check("w1_result", {31'd0, result1}, 32'd0);
    check("w1_carry", {31'd0, carry_out1}, 32'd1);
    check("w1_ovf", {31'd0, overflow1}, {31'd0, e1[32]});
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    check("w1_drop", {31'd0, out_valid1}, 32'd0);
    a1 = 1'b1; b1 = 1'b0; sub1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    e1 = model(1, 32'd1, 32'd0, 1'b1);
    check("w1_sub_valid", {31'd0, out_valid1}, 32'd1);
    check("w1_sub_result", {31'd0, result1}, {31'd0, e1[0]});
    check("w1_sub_carry", {31'd0, carry_out1}, {31'd0, e1[33]});
    check("w1_sub_ovf", {31'd0, overflow1}, {31'd0, e1[32]});
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
